// File: rtl/nibble_frame_feeder.sv
// nibble_frame_feeder: buffers whole nibble frames and replays each as one contiguous valid burst
// Ports:
//   i_clock, i_reset        rising-edge clock, asynchronous active-high reset
//   i_cfg_we, i_cfg_seq     match-value write; deferred until IDLE when a burst is in flight
//   i_in_valid, o_in_ready  ingress handshake for i_in_data / i_in_last
//   i_hit                   downstream FSM hit; bursts start and finish only while it is low
//   o_valid, o_num, o_seq   registered burst valid, nibble and match value
//   o_trunc                 one-cycle pulse when an over-long frame's tail was dropped
//   o_busy                  egress active or FIFO holding data
module nibble_frame_feeder #(
   parameter int DEPTH   = 16,
   parameter int MAX_LEN = 15,
   parameter int GAP_CYC = 2
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_cfg_we,
   input  logic [3:0] i_cfg_seq,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  logic [3:0] i_in_data,
   input  logic       i_in_last,
   input  logic       i_hit,
   output logic       o_valid,
   output logic [3:0] o_num,
   output logic [3:0] o_seq,
   output logic       o_trunc,
   output logic       o_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   typedef enum logic [2:0] {IDLE, PRE, SEND, GAP, HOLD} state_t;
   state_t        r_state, w_next;
   logic [4:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt, r_frames;
   logic [LW-1:0] r_len;
   logic [GW-1:0] r_gap;
   logic          r_valid, r_trunc, r_pend_v;
   logic [3:0]    r_num, r_seq, r_pend;
   logic [4:0]    w_head;
   logic [3:0]    w_num_d;
   logic          w_full, w_empty, w_at_max, w_hs, w_push, w_fin, w_trunc, w_pop, w_done, w_valid_d, w_enter_idle;
   assign w_full       = r_cnt == (AW+1)'(DEPTH);
   assign w_empty      = r_cnt == '0;
   assign w_at_max     = r_len >= LW'(MAX_LEN);
   // Once a frame hits MAX_LEN its tail is swallowed, so ready must stay high even when full
   assign o_in_ready   = !w_full || w_at_max;
   assign w_hs         = i_in_valid && o_in_ready;
   assign w_push       = w_hs && !w_at_max;
   assign w_fin        = w_hs && i_in_last;
   assign w_trunc      = w_fin && w_at_max;
   assign w_head       = r_mem[r_rp];
   assign w_done       = w_pop && w_head[4];
   assign w_enter_idle = (r_state != IDLE) && (w_next == IDLE);
   assign o_valid      = r_valid;
   assign o_num        = r_num;
   assign o_seq        = r_seq;
   assign o_trunc      = r_trunc;
   assign o_busy       = (r_state != IDLE) || !w_empty;
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   // The PRE nibble is ~seq so it can never match; it covers the FSM's WAIT->WATCH step
   always_comb begin
      w_next    = r_state;
      w_valid_d = 1'b0;
      w_num_d   = '0;
      w_pop     = 1'b0;
      case (r_state)
         IDLE: w_next = (r_frames != '0 && !i_hit) ? PRE : IDLE;
         PRE: begin
            w_valid_d = 1'b1;
            w_num_d   = ~r_seq;
            w_next    = SEND;
         end
         SEND: begin
            w_valid_d = 1'b1;
            w_num_d   = w_head[3:0];
            w_pop     = !w_empty;
            w_next    = (w_pop && w_head[4]) ? GAP : SEND;
         end
         GAP:     w_next = (r_gap == GW'(GAP_CYC - 1)) ? HOLD : GAP;
         HOLD:    w_next = i_hit ? HOLD : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_valid  <= 1'b0;
         r_num    <= '0;
         r_trunc  <= 1'b0;
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_frames <= '0;
         r_len    <= '0;
         r_gap    <= '0;
         r_seq    <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
      end else begin
         r_valid  <= w_valid_d;
         r_num    <= w_num_d;
         r_trunc  <= w_trunc;
         r_wp     <= r_wp + AW'(w_push);
         r_rp     <= r_rp + AW'(w_pop);
         r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_frames <= r_frames + (AW+1)'(w_fin) - (AW+1)'(w_done);
         r_len    <= w_fin ? '0 : r_len + LW'(w_push);
         r_gap    <= (r_state == GAP) ? r_gap + GW'(1) : '0;
         // seq only changes between bursts; a write arriving on the IDLE-entry edge beats the pending one
         if (r_state == IDLE) begin
            if (i_cfg_we) r_seq <= i_cfg_seq;
         end else if (w_enter_idle) begin
            r_seq    <= i_cfg_we ? i_cfg_seq : (r_pend_v ? r_pend : r_seq);
            r_pend_v <= 1'b0;
         end else if (i_cfg_we) begin
            r_pend   <= i_cfg_seq;
            r_pend_v <= 1'b1;
         end
      end
   end
   // A truncated frame has no nibble to carry its end marker, so the last stored entry is retagged
   always_ff @(posedge i_clock) begin
      if (w_push)       r_mem[r_wp] <= {i_in_last, i_in_data};
      else if (w_trunc) r_mem[r_wp - AW'(1)][4] <= 1'b1;
   end
endmodule

// File: tb/tb_nibble_frame_feeder.sv
// tb_nibble_frame_feeder: directed scenarios for nibble_frame_feeder with a burst-capturing monitor
module tb_nibble_frame_feeder;
   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_cfg_we = 1'b0;
   logic [3:0] i_cfg_seq = '0;
   logic       i_in_valid = 1'b0;
   logic       o_in_ready;
   logic [3:0] i_in_data = '0;
   logic       i_in_last = 1'b0;
   logic       i_hit = 1'b0;
   logic       o_valid;
   logic [3:0] o_num;
   logic [3:0] o_seq;
   logic       o_trunc;
   logic       o_busy;
   int vectors = 0;
   int miscompares = 0;
   logic [3:0] cap_q[$];
   int len_q[$];
   int gap_q[$];
   int run = 0;
   int low = 0;
   int trunc_cnt = 0;
   bit seen = 1'b0;

   nibble_frame_feeder dut (
      .i_clock(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_seq(i_cfg_seq),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data), .i_in_last(i_in_last),
      .i_hit(i_hit), .o_valid(o_valid), .o_num(o_num), .o_seq(o_seq), .o_trunc(o_trunc), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_trunc) trunc_cnt++;
      if (o_valid) begin
         if (run == 0 && seen) gap_q.push_back(low);
         run++;
         cap_q.push_back(o_num);
      end else begin
         if (run > 0) begin
            len_q.push_back(run);
            run = 0;
            seen = 1'b1;
            low = 0;
         end
         low++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon;
      cap_q.delete();
      len_q.delete();
      gap_q.delete();
      seen = 1'b0;
      low = 0;
      trunc_cnt = 0;
   endtask

   task automatic push(input logic [3:0] d, input logic last);
      int t = 0;
      i_in_valid = 1'b1;
      i_in_data = d;
      i_in_last = last;
      while (!o_in_ready && t < 300) begin
         tick(1);
         t++;
      end
      if (t >= 300) begin
         vectors++;
         miscompares++;
         $display("FAIL push_timeout: in_ready=%b, want 1", o_in_ready);
      end
      tick(1);
      i_in_valid = 1'b0;
      i_in_last = 1'b0;
   endtask

   task automatic wait_valid(input logic lvl);
      int t = 0;
      while (o_valid !== lvl && t < 300) begin
         tick(1);
         t++;
      end
      if (t >= 300) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_valid_timeout: valid=%b, want %b", o_valid, lvl);
      end
   endtask

   task automatic wait_idle;
      int t = 0;
      while ((o_busy || o_valid) && t < 600) begin
         tick(1);
         t++;
      end
      if (t >= 600) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle_timeout: busy=%b valid=%b, want 0 0", o_busy, o_valid);
      end
   endtask

   task automatic test_reset;
      tick(2);
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, want 0", o_valid); end
      vectors++; if (o_num !== 4'h0) begin miscompares++; $display("FAIL reset_num: got %h, want 0", o_num); end
      vectors++; if (o_seq !== 4'h0) begin miscompares++; $display("FAIL reset_seq: got %h, want 0", o_seq); end
      vectors++; if (o_trunc !== 1'b0) begin miscompares++; $display("FAIL reset_trunc: got %b, want 0", o_trunc); end
      vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, want 1", o_in_ready); end
      vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, want 0", o_busy); end
      i_reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single_frame;
      logic [3:0] exp [5] = '{4'hA, 4'h5, 4'h3, 4'h5, 4'h5};
      logic [3:0] got;
      i_cfg_we = 1'b1;
      i_cfg_seq = 4'h5;
      tick(1);
      i_cfg_we = 1'b0;
      vectors++; if (o_seq !== 4'h5) begin miscompares++; $display("FAIL cfg_idle_seq: got %h, want 5", o_seq); end
      clear_mon();
      push(4'h5, 1'b0);
      push(4'h3, 1'b0);
      push(4'h5, 1'b0);
      push(4'h5, 1'b1);
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL lat_k: valid=%b, want 0", o_valid); end
      tick(1);
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL lat_k1: valid=%b, want 0", o_valid); end
      tick(1);
      vectors++; if (o_valid !== 1'b1 || o_num !== 4'hA) begin miscompares++; $display("FAIL lat_k2: valid=%b num=%h, want 1 a", o_valid, o_num); end
      wait_idle();
      tick(2);
      vectors++; if (len_q.size() != 1 || len_q[0] != 5) begin miscompares++; $display("FAIL single_len: bursts=%0d first=%0d, want 1 5", len_q.size(), (len_q.size() > 0) ? len_q[0] : -1); end
      for (int i = 0; i < 5; i++) begin
         got = (i < cap_q.size()) ? cap_q[i] : 4'bx;
         vectors++; if (got !== exp[i]) begin miscompares++; $display("FAIL single_num[%0d]: got %h, want %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp [7] = '{4'hA, 4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'h6};
      logic [3:0] got;
      clear_mon();
      push(4'h1, 1'b0);
      push(4'h2, 1'b1);
      push(4'h3, 1'b0);
      push(4'h4, 1'b0);
      push(4'h6, 1'b1);
      wait_valid(1'b0);
      i_hit = 1'b1;
      tick(4);
      i_hit = 1'b0;
      wait_idle();
      tick(2);
      vectors++; if (len_q.size() != 2) begin miscompares++; $display("FAIL b2b_bursts: got %0d, want 2", len_q.size()); end
      vectors++; if (len_q.size() < 2 || len_q[0] != 3 || len_q[1] != 4) begin miscompares++; $display("FAIL b2b_lens: got %p, want 3 4", len_q); end
      vectors++; if (gap_q.size() < 1 || gap_q[0] != 7) begin miscompares++; $display("FAIL b2b_gap: got %p, want 7", gap_q); end
      for (int i = 0; i < 7; i++) begin
         got = (i < cap_q.size()) ? cap_q[i] : 4'bx;
         vectors++; if (got !== exp[i]) begin miscompares++; $display("FAIL b2b_num[%0d]: got %h, want %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_trunc;
      int bad_ready = 0;
      clear_mon();
      for (int i = 1; i <= 18; i++) begin
         logic [3:0] d;
         d = 4'(i);
         if (o_in_ready !== 1'b1) bad_ready++;
         push(d, i == 18);
      end
      vectors++; if (bad_ready != 0) begin miscompares++; $display("FAIL trunc_ready: %0d nibbles saw ready low, want 0", bad_ready); end
      vectors++; if (o_trunc !== 1'b1) begin miscompares++; $display("FAIL trunc_pulse: got %b, want 1", o_trunc); end
      tick(1);
      vectors++; if (o_trunc !== 1'b0) begin miscompares++; $display("FAIL trunc_pulse_end: got %b, want 0", o_trunc); end
      wait_idle();
      tick(2);
      vectors++; if (trunc_cnt != 1) begin miscompares++; $display("FAIL trunc_count: got %0d, want 1", trunc_cnt); end
      vectors++; if (len_q.size() != 1 || len_q[0] != 16) begin miscompares++; $display("FAIL trunc_len: got %p, want 16", len_q); end
      vectors++; if (cap_q.size() < 16 || cap_q[1] !== 4'h1) begin miscompares++; $display("FAIL trunc_first: got %p, want first data 1", cap_q); end
      vectors++; if (cap_q.size() < 16 || cap_q[15] !== 4'hF) begin miscompares++; $display("FAIL trunc_final: got %p, want final f", cap_q); end
   endtask

   task automatic test_fill;
      logic [3:0] got;
      clear_mon();
      i_hit = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] d;
         d = 4'(i);
         push(d, 1'b1);
      end
      vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %b, want 0", o_in_ready); end
      vectors++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL fill_hold: busy=%b valid=%b, want 1 0", o_busy, o_valid); end
      i_hit = 1'b0;
      tick(1);
      vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_e1: got %b, want 0", o_in_ready); end
      tick(1);
      vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_e2: got %b, want 0", o_in_ready); end
      tick(1);
      vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_pop: got %b, want 1", o_in_ready); end
      wait_idle();
      tick(2);
      vectors++; if (len_q.size() != 16) begin miscompares++; $display("FAIL fill_bursts: got %0d, want 16", len_q.size()); end
      for (int i = 0; i < 16; i++) begin
         got = (2 * i + 1 < cap_q.size()) ? cap_q[2*i+1] : 4'bx;
         vectors++; if (got !== 4'(i) || (i < len_q.size() && len_q[i] != 2)) begin miscompares++; $display("FAIL fill_frame[%0d]: num=%h len=%0d, want %h 2", i, got, (i < len_q.size()) ? len_q[i] : -1, 4'(i)); end
      end
   endtask

   task automatic test_cfg_pending;
      clear_mon();
      push(4'h1, 1'b0);
      push(4'h2, 1'b0);
      push(4'h3, 1'b0);
      push(4'h4, 1'b1);
      wait_valid(1'b1);
      tick(2);
      i_cfg_we = 1'b1;
      i_cfg_seq = 4'h7;
      tick(1);
      i_cfg_seq = 4'h9;
      vectors++; if (o_seq !== 4'h5) begin miscompares++; $display("FAIL cfg_send_seq: got %h, want 5", o_seq); end
      tick(1);
      i_cfg_we = 1'b0;
      wait_valid(1'b0);
      vectors++; if (o_seq !== 4'h5) begin miscompares++; $display("FAIL cfg_gap_seq: got %h, want 5", o_seq); end
      wait_idle();
      vectors++; if (o_seq !== 4'h9) begin miscompares++; $display("FAIL cfg_idle_apply: got %h, want 9", o_seq); end
      tick(2);
      vectors++; if (cap_q.size() != 5 || cap_q[0] !== 4'hA || cap_q[4] !== 4'h4) begin miscompares++; $display("FAIL cfg_burst: got %p, want a 1 2 3 4", cap_q); end
   endtask

   task automatic test_reset_mid;
      push(4'h1, 1'b0);
      push(4'h2, 1'b0);
      push(4'h3, 1'b0);
      push(4'h4, 1'b0);
      push(4'h5, 1'b0);
      push(4'h6, 1'b0);
      push(4'h7, 1'b0);
      push(4'h8, 1'b1);
      push(4'hC, 1'b0);
      push(4'hD, 1'b0);
      vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b, want 1", o_valid); end
      #2;
      i_reset = 1'b1;
      #1;
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b, want 0", o_valid); end
      vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b, want 0", o_busy); end
      vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b, want 1", o_in_ready); end
      vectors++; if (o_seq !== 4'h0) begin miscompares++; $display("FAIL mid_seq: got %h, want 0", o_seq); end
      tick(1);
      i_reset = 1'b0;
      tick(1);
      clear_mon();
      tick(10);
      vectors++; if (cap_q.size() != 0) begin miscompares++; $display("FAIL mid_no_replay: got %0d valid cycles, want 0", cap_q.size()); end
      push(4'h7, 1'b1);
      wait_idle();
      tick(2);
      vectors++; if (cap_q.size() != 2 || cap_q[0] !== 4'hF || cap_q[1] !== 4'h7) begin miscompares++; $display("FAIL mid_after: got %p, want f 7", cap_q); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_trunc();
      test_fill();
      test_cfg_pending();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
